// File: rtl/chr_byte_loader.sv
// chr_byte_loader: stream-to-RAM write master with per-byte readback verify.
// Accepts i_len bytes over a valid/ready stream and writes them to consecutive
// RAM addresses starting at i_base (wrapping at the top of the address space).
// Each byte is read back one cycle after its write and compared.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_start, i_base, i_len        load request (sampled only in IDLE)
//   i_byte, i_byte_valid,
//   o_byte_ready                  input byte stream handshake
//   o_ram_addr, o_ram_data,
//   o_ram_w_n, i_ram_q            RAM write port / combinational read data
//   o_busy, o_done                status: not idle / one-cycle completion pulse
//   o_error, o_err_addr,
//   o_err_cnt                     sticky mismatch flag, first bad address, count
module chr_byte_loader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [ADDR_WIDTH:0]   i_len,
    input  logic [DATA_WIDTH-1:0] i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    output logic                  o_ram_w_n,
    input  logic [DATA_WIDTH-1:0] i_ram_q,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH-1:0] o_err_addr,
    output logic [ADDR_WIDTH:0]   o_err_cnt
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     cnt_q;
    logic [DATA_WIDTH-1:0] exp_q;

    logic [LEN_W-1:0]     cnt_inc_c;
    logic                 last_c;
    logic                 mismatch_c;

    // Byte bookkeeping and readback compare
    assign cnt_inc_c  = cnt_q + LEN_W'(1);
    assign last_c     = (cnt_inc_c == len_q);
    assign mismatch_c = (i_ram_q != exp_q);

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_next = (i_len == LEN_W'(0)) ? S_DONE : S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (i_byte_valid) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE:  state_next = S_CHECK;
            S_CHECK:  state_next = last_c ? S_DONE : S_ACCEPT;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // State register, registered status outputs and datapath
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            o_byte_ready <= 1'b0;
            o_ram_w_n    <= 1'b1;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_ram_addr   <= '0;
            o_ram_data   <= '0;
            o_error      <= 1'b0;
            o_err_addr   <= '0;
            o_err_cnt    <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            exp_q        <= '0;
        end else begin
            state <= state_next;
            // Status flags are decoded from the next state so they line up with it
            o_byte_ready <= (state_next == S_ACCEPT);
            o_ram_w_n    <= (state_next != S_WRITE);
            o_busy       <= (state_next != S_IDLE);
            o_done       <= (state_next == S_DONE);

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        len_q      <= i_len;
                        cnt_q      <= '0;
                        o_error    <= 1'b0;
                        o_err_addr <= '0;
                        o_err_cnt  <= '0;
                        o_ram_addr <= i_base;
                    end
                end
                S_ACCEPT: begin
                    if (i_byte_valid) begin
                        o_ram_data <= i_byte;
                        exp_q      <= i_byte;
                    end
                end
                S_CHECK: begin
                    if (mismatch_c) begin
                        o_error <= 1'b1;
                        if (o_err_cnt != {LEN_W{1'b1}}) begin
                            o_err_cnt <= o_err_cnt + LEN_W'(1);
                        end
                        // error is cleared at start, so low here means first mismatch
                        if (!o_error) begin
                            o_err_addr <= o_ram_addr;
                        end
                    end
                    cnt_q <= cnt_inc_c;
                    // On the last byte the address stays on the final written location
                    if (!last_c) begin
                        o_ram_addr <= o_ram_addr + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chr_byte_loader.sv
// Directed bench for chr_byte_loader: a 16-bit-address instance for the
// functional scenarios and an 8-bit-address instance for the full-space load.
module tb_chr_byte_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  byte_in;
    logic        valid;

    // 16-bit address instance
    logic        start_a;
    logic [15:0] base_a;
    logic [16:0] len_a;
    logic        ready_a, w_n_a, busy_a, done_a, error_a;
    logic [15:0] addr_a, err_addr_a;
    logic [7:0]  data_a, q_a;
    logic [16:0] err_cnt_a;
    logic        inject_a;
    logic [7:0]  mem_a [0:65535];

    // 8-bit address instance
    logic        start_b;
    logic [7:0]  base_b;
    logic [8:0]  len_b;
    logic        ready_b, w_n_b, busy_b, done_b, error_b;
    logic [7:0]  addr_b, err_addr_b;
    logic [7:0]  data_b, q_b;
    logic [8:0]  err_cnt_b;
    logic [7:0]  mem_b [0:255];

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int wr_a = 0, hs_a = 0, dn_a = 0, rdy_a = 0;
    int wr_b = 0, dn_b = 0;
    logic [15:0] wa_a[$];
    int          hsc_a[$];

    chr_byte_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_base(base_a), .i_len(len_a),
        .i_byte(byte_in), .i_byte_valid(valid), .o_byte_ready(ready_a),
        .o_ram_addr(addr_a), .o_ram_data(data_a), .o_ram_w_n(w_n_a), .i_ram_q(q_a),
        .o_busy(busy_a), .o_done(done_a), .o_error(error_a),
        .o_err_addr(err_addr_a), .o_err_cnt(err_cnt_a)
    );

    chr_byte_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_base(base_b), .i_len(len_b),
        .i_byte(byte_in), .i_byte_valid(valid), .o_byte_ready(ready_b),
        .o_ram_addr(addr_b), .o_ram_data(data_b), .o_ram_w_n(w_n_b), .i_ram_q(q_b),
        .o_busy(busy_b), .o_done(done_b), .o_error(error_b),
        .o_err_addr(err_addr_b), .o_err_cnt(err_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: synchronous write, combinational read; bit0 corruption on demand
    always @(posedge clk) if (!w_n_a) mem_a[addr_a] <= data_a;
    always @(posedge clk) if (!w_n_b) mem_b[addr_b] <= data_b;
    assign q_a = mem_a[addr_a] ^ {7'b0, inject_a & (addr_a == 16'h0201 || addr_a == 16'h0203)};
    assign q_b = mem_b[addr_b];

    // Event monitors
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!w_n_a) begin wr_a = wr_a + 1; wa_a.push_back(addr_a); end
        if (ready_a) rdy_a = rdy_a + 1;
        if (ready_a && valid) begin hs_a = hs_a + 1; hsc_a.push_back(cyc); end
        if (done_a) dn_a = dn_a + 1;
        if (!w_n_b) wr_b = wr_b + 1;
        if (done_b) dn_b = dn_b + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total = total + 1;
        assert (obs === expv) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_ready(input bit sel);
        int n = 0;
        while (!(sel ? ready_b : ready_a) && n < 50) begin tick(); n++; end
        if (n >= 50) chk("ready_timeout", 32'(sel ? ready_b : ready_a), 32'd1);
    endtask

    task automatic send_one(input bit sel, input logic [7:0] b);
        byte_in = b;
        valid   = 1'b1;
        wait_ready(sel);
        tick();
    endtask

    task automatic wait_done(input bit sel);
        int n = 0;
        while (!(sel ? done_b : done_a) && n < 50) begin tick(); n++; end
        chk("done_seen", 32'(sel ? done_b : done_a), 32'd1);
        tick();
        chk("done_one_cycle", 32'(sel ? done_b : done_a), 32'd0);
        chk("idle_after_done", 32'(sel ? busy_b : busy_a), 32'd0);
    endtask

    task automatic start_a_load(input logic [15:0] b, input logic [16:0] l);
        base_a  = b;
        len_a   = l;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    initial begin
        int w0, h0, d0, r0, q0;
        logic [7:0] t1 [4];
        logic [7:0] t3 [4];
        t1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        t3 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; valid = 1'b0; byte_in = 8'h00;
        base_a = '0; len_a = '0; base_b = '0; len_b = '0; inject_a = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_w_n", 32'(w_n_a), 32'd1);
        chk("rst_addr", 32'(addr_a), 32'h0);
        chk("rst_data", 32'(data_a), 32'h0);
        chk("rst_ready", 32'(ready_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_error", 32'(error_a), 32'd0);
        chk("rst_err_addr", 32'(err_addr_a), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt_a), 32'h0);
        rst = 1'b0;
        tick();

        // Test 1: four bytes from 0x0100 with valid held high
        w0 = wr_a; h0 = hs_a; d0 = dn_a; q0 = wa_a.size();
        valid = 1'b1;
        start_a_load(16'h0100, 17'd4);
        chk("t1_busy", 32'(busy_a), 32'd1);
        for (int i = 0; i < 4; i++) send_one(1'b0, t1[i]);
        wait_done(1'b0);
        chk("t1_writes", 32'(wr_a - w0), 32'd4);
        chk("t1_handshakes", 32'(hs_a - h0), 32'd4);
        chk("t1_done_cnt", 32'(dn_a - d0), 32'd1);
        chk("t1_error", 32'(error_a), 32'd0);
        for (int i = 0; i < 4; i++) chk("t1_waddr", 32'(wa_a[q0 + i]), 32'h0100 + 32'(i));
        for (int i = 1; i < 4; i++)
            chk("t1_hs_spacing", 32'(hsc_a[h0 + i] - hsc_a[h0 + i - 1]), 32'd3);
        chk("t1_mem_0102", 32'(mem_a[16'h0102]), 32'h33);
        chk("t1_mem_0103", 32'(mem_a[16'h0103]), 32'h44);

        // Test 2: zero-length load
        w0 = wr_a; h0 = hs_a; d0 = dn_a; r0 = rdy_a;
        valid = 1'b1;
        start_a_load(16'h0500, 17'd0);
        chk("t2_done_next", 32'(done_a), 32'd1);
        tick();
        chk("t2_done_drop", 32'(done_a), 32'd0);
        tick();
        chk("t2_writes", 32'(wr_a - w0), 32'd0);
        chk("t2_ready_never", 32'(rdy_a - r0), 32'd0);
        chk("t2_handshakes", 32'(hs_a - h0), 32'd0);
        chk("t2_done_cnt", 32'(dn_a - d0), 32'd1);
        chk("t2_error", 32'(error_a), 32'd0);

        // Test 3: wrap past the top address
        q0 = wa_a.size();
        start_a_load(16'hFFFE, 17'd4);
        for (int i = 0; i < 4; i++) send_one(1'b0, t3[i]);
        wait_done(1'b0);
        chk("t3_waddr0", 32'(wa_a[q0]), 32'hFFFE);
        chk("t3_waddr1", 32'(wa_a[q0 + 1]), 32'hFFFF);
        chk("t3_waddr2", 32'(wa_a[q0 + 2]), 32'h0000);
        chk("t3_waddr3", 32'(wa_a[q0 + 3]), 32'h0001);
        chk("t3_mem_ffff", 32'(mem_a[16'hFFFF]), 32'hA1);
        chk("t3_mem_0000", 32'(mem_a[16'h0000]), 32'hA2);
        chk("t3_error", 32'(error_a), 32'd0);

        // Test 4: corrupted readback on 2nd and 4th byte
        inject_a = 1'b1;
        start_a_load(16'h0200, 17'd5);
        for (int i = 0; i < 5; i++) send_one(1'b0, 8'h60 + 8'(i));
        wait_done(1'b0);
        chk("t4_error", 32'(error_a), 32'd1);
        chk("t4_err_addr", 32'(err_addr_a), 32'h0201);
        chk("t4_err_cnt", 32'(err_cnt_a), 32'd2);
        inject_a = 1'b0;
        tick(); tick();
        chk("t4_error_holds", 32'(error_a), 32'd1);
        start_a_load(16'h0300, 17'd1);
        chk("t4_clr_error", 32'(error_a), 32'd0);
        chk("t4_clr_err_addr", 32'(err_addr_a), 32'h0);
        chk("t4_clr_err_cnt", 32'(err_cnt_a), 32'h0);
        send_one(1'b0, 8'h77);
        wait_done(1'b0);
        chk("t4_clean_error", 32'(error_a), 32'd0);

        // Test 5: stall, ignored start while busy, reset during WRITE
        d0 = dn_a; q0 = wa_a.size();
        start_a_load(16'h0400, 17'd4);
        send_one(1'b0, 8'h51);
        send_one(1'b0, 8'h52);
        valid = 1'b0;
        wait_ready(1'b0);
        w0 = wr_a;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin base_a = 16'h0800; len_a = 17'd2; start_a = 1'b1; end
            tick();
            start_a = 1'b0;
        end
        chk("t5_stall_writes", 32'(wr_a - w0), 32'd0);
        chk("t5_stall_busy", 32'(busy_a), 32'd1);
        chk("t5_stall_ready", 32'(ready_a), 32'd1);
        chk("t5_stall_addr", 32'(addr_a), 32'h0402);
        send_one(1'b0, 8'h53);
        chk("t5_in_write", 32'(w_n_a), 32'd0);
        valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_w_n", 32'(w_n_a), 32'd1);
        chk("t5_rst_busy", 32'(busy_a), 32'd0);
        chk("t5_rst_done", 32'(done_a), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        chk("t5_total_writes", 32'(wa_a.size() - q0), 32'd3);
        chk("t5_third_addr", 32'(wa_a[q0 + 2]), 32'h0402);
        chk("t5_no_done", 32'(dn_a - d0), 32'd0);
        chk("t5_idle_busy", 32'(busy_a), 32'd0);

        // Test 6: full 256-byte load on the 8-bit-address instance
        w0 = wr_b; d0 = dn_b;
        base_b = 8'h40; len_b = 9'h100; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 256; i++) send_one(1'b1, 8'(i));
        valid = 1'b0;
        wait_done(1'b1);
        chk("t6_writes", 32'(wr_b - w0), 32'd256);
        chk("t6_done_cnt", 32'(dn_b - d0), 32'd1);
        chk("t6_error", 32'(error_b), 32'd0);
        chk("t6_err_cnt", 32'(err_cnt_b), 32'd0);
        chk("t6_err_addr", 32'(err_addr_b), 32'h0);
        chk("t6_final_addr", 32'(addr_b), 32'h3F);
        chk("t6_mem_40", 32'(mem_b[8'h40]), 32'h00);
        chk("t6_mem_80", 32'(mem_b[8'h80]), 32'h40);
        chk("t6_mem_3f", 32'(mem_b[8'h3F]), 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
